// File: rtl/chimera_pkg.sv
// Shared types and helpers for the chimera AXI master: FSM state encoding,
// AXI response codes and the beat-count ceiling division.
package chimera_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_AW,
        WR_W,
        WR_B,
        RD_AR,
        RD_R,
        OUT
    } state_t;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/chimera_axi_master.sv
// AXI4 master that writes one task word as a single burst and, on request,
// reads one result word back as a single burst and presents it on a stream.
module chimera_axi_master
    import chimera_pkg::*;
#(
    parameter int          AXI_DWIDTH  = 64,
    parameter int          TASK_SIZE   = 208,
    parameter int          RESULT_SIZE = 336,
    parameter logic [63:0] WR_ADDR     = 64'h0,
    parameter logic [63:0] RD_ADDR     = 64'h0,
    parameter logic [3:0]  AXI_ID      = 4'h0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   task_valid,
    output logic                   task_ready,
    input  logic [TASK_SIZE-1:0]   task_data,
    input  logic                   rd_req,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [RESULT_SIZE-1:0] result_data,
    output logic                   m_axi_awvalid,
    input  logic                   m_axi_awready,
    output logic [63:0]            m_axi_awaddr,
    output logic [7:0]             m_axi_awlen,
    output logic [3:0]             m_axi_awid,
    output logic                   m_axi_wvalid,
    input  logic                   m_axi_wready,
    output logic [AXI_DWIDTH-1:0]  m_axi_wdata,
    output logic                   m_axi_wlast,
    input  logic                   m_axi_bvalid,
    output logic                   m_axi_bready,
    input  logic [3:0]             m_axi_bid,
    input  logic [1:0]             m_axi_bresp,
    output logic                   m_axi_arvalid,
    input  logic                   m_axi_arready,
    output logic [63:0]            m_axi_araddr,
    output logic [7:0]             m_axi_arlen,
    output logic [3:0]             m_axi_arid,
    input  logic                   m_axi_rvalid,
    output logic                   m_axi_rready,
    input  logic [AXI_DWIDTH-1:0]  m_axi_rdata,
    input  logic                   m_axi_rlast,
    input  logic [3:0]             m_axi_rid,
    input  logic [1:0]             m_axi_rresp,
    output logic                   err
);

    localparam int WB = ceil_div(TASK_SIZE, AXI_DWIDTH);
    localparam int RB = ceil_div(RESULT_SIZE, AXI_DWIDTH);
    localparam int TW = WB * AXI_DWIDTH;
    localparam int RW = RB * AXI_DWIDTH;

    state_t          state;
    logic [7:0]      beat;
    logic [7:0]      beat_inc;
    logic            pend;
    logic            last_r;
    logic [TW-1:0]   task_buf;
    logic [RW-1:0]   res_buf;
    logic [RW-1:0]   res_next;
    logic            unused;

    // Burst address/length/id are fixed by parameters, so they are constants.
    assign m_axi_awaddr = WR_ADDR;
    assign m_axi_awlen  = 8'(WB - 1);
    assign m_axi_awid   = AXI_ID;
    assign m_axi_araddr = RD_ADDR;
    assign m_axi_arlen  = 8'(RB - 1);
    assign m_axi_arid   = AXI_ID;

    assign beat_inc = beat + 8'd1;
    assign last_r   = (beat == 8'(RB - 1));
    assign unused   = ^{m_axi_rid, res_next};

    // Result word including the beat arriving this cycle, so OUT can be
    // entered one cycle after the final R beat.
    always_comb begin
        res_next = res_buf;
        res_next[32'(beat) * AXI_DWIDTH +: AXI_DWIDTH] = m_axi_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            beat          <= '0;
            pend          <= 1'b0;
            task_buf      <= '0;
            res_buf       <= '0;
            task_ready    <= 1'b1;
            result_valid  <= 1'b0;
            result_data   <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wlast   <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            err           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A waiting task always takes priority over a pending read.
                    if (task_valid) begin
                        task_buf      <= TW'(task_data);
                        task_ready    <= 1'b0;
                        m_axi_awvalid <= 1'b1;
                        state         <= WR_AW;
                    end else if (pend) begin
                        pend          <= 1'b0;
                        task_ready    <= 1'b0;
                        m_axi_arvalid <= 1'b1;
                        state         <= RD_AR;
                    end
                end
                WR_AW: if (m_axi_awready) begin
                    m_axi_awvalid <= 1'b0;
                    m_axi_wvalid  <= 1'b1;
                    m_axi_wdata   <= task_buf[AXI_DWIDTH-1:0];
                    m_axi_wlast   <= (WB == 1);
                    beat          <= '0;
                    state         <= WR_W;
                end
                WR_W: if (m_axi_wready) begin
                    if (m_axi_wlast) begin
                        m_axi_wvalid <= 1'b0;
                        m_axi_wlast  <= 1'b0;
                        m_axi_bready <= 1'b1;
                        state        <= WR_B;
                    end else begin
                        beat        <= beat_inc;
                        m_axi_wdata <= task_buf[32'(beat_inc) * AXI_DWIDTH +: AXI_DWIDTH];
                        m_axi_wlast <= (beat_inc == 8'(WB - 1));
                    end
                end
                WR_B: if (m_axi_bvalid) begin
                    m_axi_bready <= 1'b0;
                    if (m_axi_bresp != AXI_RESP_OKAY || m_axi_bid != AXI_ID)
                        err <= 1'b1;
                    task_ready <= 1'b1;
                    state      <= IDLE;
                end
                RD_AR: if (m_axi_arready) begin
                    m_axi_arvalid <= 1'b0;
                    m_axi_rready  <= 1'b1;
                    beat          <= '0;
                    state         <= RD_R;
                end
                RD_R: if (m_axi_rvalid) begin
                    res_buf <= res_next;
                    if (m_axi_rresp != AXI_RESP_OKAY || m_axi_rlast != last_r)
                        err <= 1'b1;
                    // Beat count, not rlast, ends the burst.
                    if (last_r) begin
                        m_axi_rready <= 1'b0;
                        result_valid <= 1'b1;
                        result_data  <= res_next[RESULT_SIZE-1:0];
                        beat         <= '0;
                        state        <= OUT;
                    end else begin
                        beat <= beat_inc;
                    end
                end
                OUT: if (result_ready) begin
                    result_valid <= 1'b0;
                    task_ready   <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (rd_req)
                pend <= 1'b1;
        end
    end

endmodule
